// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter that multiplexes an instruction-fetch port and a data
// load/store port onto one shared memory request/response port. Exactly one
// transaction is in flight at a time; stores complete on the request
// handshake, while fetches and loads wait for the read response.
module mem_bus_arbiter #(
  parameter int RR = 1  // 1: round-robin on conflict, 0: data always wins
) (
  input  logic        clk,
  input  logic        rst,
  // Instruction fetch port
  input  logic [31:0] PC,
  input  logic        Inst_Req_Valid,
  output logic        Inst_Req_Ready,
  output logic [31:0] Instruction,
  output logic        Inst_Valid,
  input  logic        Inst_Ready,
  // Data load/store port
  input  logic [31:0] Address,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] Write_data,
  input  logic [3:0]  Write_strb,
  output logic        Mem_Req_Ready,
  output logic [31:0] Read_data,
  output logic        Read_data_Valid,
  input  logic        Read_data_Ready,
  // Shared memory port
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_wen,
  output logic [3:0]  bus_strb,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  input  logic [31:0] bus_rdata,
  input  logic        bus_rvalid,
  output logic        bus_rready,
  // Statistics
  output logic [31:0] conflict_cnt
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] GNT_I  = 3'd1;
  localparam logic [2:0] GNT_D  = 3'd2;
  localparam logic [2:0] WAIT_I = 3'd3;
  localparam logic [2:0] WAIT_D = 3'd4;

  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

  logic [2:0]  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] conflict_cnt_q, conflict_cnt_d;

  logic data_req;
  logic both_req;
  logic data_wins;

  // A simultaneous read+write is handled as a write.
  assign data_req  = MemRead | MemWrite;
  assign both_req  = Inst_Req_Valid & data_req;
  assign data_wins = (RR == 0) ? 1'b1 : (last_grant_q == LAST_I);

  // Next-state, grant history and conflict counter.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    conflict_cnt_d = conflict_cnt_q;
    case (state_q)
      IDLE: begin
        if (both_req) begin
          conflict_cnt_d = conflict_cnt_q + 32'd1;
          state_d        = data_wins ? GNT_D : GNT_I;
        end else if (Inst_Req_Valid) begin
          state_d = GNT_I;
        end else if (data_req) begin
          state_d = GNT_D;
        end
      end
      GNT_I: begin
        if (!Inst_Req_Valid) begin
          state_d = IDLE;
        end else if (bus_req_ready) begin
          state_d      = WAIT_I;
          last_grant_d = LAST_I;
        end
      end
      GNT_D: begin
        if (!data_req) begin
          state_d = IDLE;
        end else if (bus_req_ready) begin
          state_d      = MemWrite ? IDLE : WAIT_D;
          last_grant_d = LAST_D;
        end
      end
      WAIT_I: if (bus_rvalid && Inst_Ready)      state_d = IDLE;
      WAIT_D: if (bus_rvalid && Read_data_Ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous reset; a reset abandons any transfer.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      last_grant_q   <= LAST_I;
      conflict_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  // Output decode: bus request fields pass through from the granted master,
  // response fields pass back only in the matching WAIT state.
  always_comb begin
    Inst_Req_Ready  = 1'b0;
    Mem_Req_Ready   = 1'b0;
    Instruction     = '0;
    Inst_Valid      = 1'b0;
    Read_data       = '0;
    Read_data_Valid = 1'b0;
    bus_addr        = '0;
    bus_wdata       = '0;
    bus_wen         = 1'b0;
    bus_strb        = 4'b0000;
    bus_req_valid   = 1'b0;
    bus_rready      = 1'b0;
    case (state_q)
      GNT_I: begin
        // Request is withdrawn with the master's valid so an aborted grant
        // can never complete a handshake on the shared port.
        bus_req_valid  = Inst_Req_Valid;
        bus_addr       = PC;
        Inst_Req_Ready = bus_req_ready;
      end
      GNT_D: begin
        bus_req_valid = data_req;
        bus_addr      = Address;
        bus_wen       = MemWrite;
        bus_wdata     = MemWrite ? Write_data : 32'd0;
        bus_strb      = MemWrite ? Write_strb : 4'b0000;
        Mem_Req_Ready = bus_req_ready;
      end
      WAIT_I: begin
        Inst_Valid  = bus_rvalid;
        Instruction = bus_rvalid ? bus_rdata : 32'd0;
        bus_rready  = Inst_Ready;
      end
      WAIT_D: begin
        Read_data_Valid = bus_rvalid;
        Read_data       = bus_rvalid ? bus_rdata : 32'd0;
        bus_rready      = Read_data_Ready;
      end
      default: ;
    endcase
  end

  assign conflict_cnt = conflict_cnt_q;

endmodule
